// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// funct3 codes, FSM state type and byte-lane helper functions.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2
    } size_e;

    // Unused funct3 codes (011/110/111) fall through to word accesses.
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        sz = SzWord;
        case (f3)
            F3_LB, F3_LBU: sz = SzByte;
            F3_LH, F3_LHU: sz = SzHalf;
            default:       sz = SzWord;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (f3_size(f3))
            SzByte:  be = 4'(4'b0001 << off);
            SzHalf:  be = 4'(4'b0011 << {off[1], 1'b0});
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane it may land in.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        d = wd;
        case (f3_size(f3))
            SzByte:  d = {4{wd[7:0]}};
            SzHalf:  d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage unit (master)
// and the data memory (slave).
interface mem_access_unit_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/load_align.sv
// Load result alignment: picks the addressed byte/half lane out of the
// memory word and sign- or zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane select and extension.
    always_comb begin
        lane_b = 8'h00;
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (off)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        case (funct3)
            F3_LB:   data = {{24{lane_b[7]}}, lane_b};
            F3_LBU:  data = {24'h000000, lane_b};
            F3_LH:   data = {{16{lane_h[15]}}, lane_h};
            F3_LHU:  data = {16'h0000, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Runs one req/ack transaction per load
// or store, stalling the upstream pipeline until it completes, and holds the
// extended load result for the MEM/WB register.
// Optional feature: MEM_ACCESS_MISALIGN_TRAP_EN adds misalign_o and skips the
// memory access for misaligned half/word accesses.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,      // active-high async reset
    input  logic                      MemRead_i,
    input  logic                      MemWrite_i,
    input  logic [2:0]                funct3_i,
    input  logic [31:0]               addr_i,
    input  logic [31:0]               wdata_i,
    output logic                      stall_o,
    output logic [31:0]               data_o,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    output logic                      misalign_o,
`endif
    mem_access_unit_if.master         dmem
);

    state_e      state_q, state_d;
    logic        latch;
    logic        load_en;
    logic        access;

    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] data_q;
    logic [31:0] load_data;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        misaligned;
    logic        mis_d, mis_q;

    // Half needs addr[0]==0; word needs both low bits clear.
    always_comb begin
        case (f3_size(funct3_i))
            SzHalf:  misaligned = addr_i[0];
            SzWord:  misaligned = |addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`endif

    assign access = MemRead_i | MemWrite_i;

    // Next-state, stall and capture enables.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        latch   = 1'b0;
        load_en = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (access) begin
                    stall_o = 1'b1;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        mis_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        latch   = 1'b1;
                        state_d = StReq;
                    end
`else
                    latch   = 1'b1;
                    state_d = StReq;
`endif
                end
            end
            StReq: begin
                stall_o = 1'b1;
                if (dmem.dmem_ack) begin
                    load_en = ~we_q;
                    state_d = StDone;
                end
            end
            // DONE releases the pipeline; the instruction still on the inputs
            // has completed and must not be re-issued.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields captured on issue, held stable through REQ.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
        end else if (latch) begin
            addr_q  <= {addr_i[31:2], 2'b00};
            be_q    <= byte_en(funct3_i, addr_i[1:0]);
            wdata_q <= store_data(funct3_i, wdata_i);
            we_q    <= MemWrite_i;
            off_q   <= addr_i[1:0];
            f3_q    <= funct3_i;
        end
    end

    load_align u_load_align (
        .rdata  (dmem.dmem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    // Load result register; only a read acknowledge updates it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            data_q <= 32'h0;
        end else if (load_en) begin
            data_q <= load_data;
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    // Misalign flag is high exactly for the DONE cycle of a trapped access.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign misalign_o = mis_q;
`endif

    assign dmem.dmem_req   = (state_q == StReq);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign data_o          = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Inputs change 1ns after the rising
// edge; outputs are checked on the falling edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] data;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    mem_access_unit_if dmem_if ();

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemRead_i  (MemRead),
        .MemWrite_i (MemWrite),
        .funct3_i   (funct3),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .stall_o    (stall),
        .data_o     (data),
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        .misalign_o (misalign),
`endif
        .dmem       (dmem_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; starts and ends 1ns after a rising edge.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rword, input int waits,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
        MemRead  = rd;
        MemWrite = wr;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        @(negedge clk);
        chk("idle_stall", {31'b0, stall}, 32'd1);
        chk("idle_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        next_cycle;
        for (int i = 0; i <= waits; i++) begin
            dmem_if.dmem_ack   = (i == waits);
            dmem_if.dmem_rdata = rword;
            @(negedge clk);
            chk("req_req", {31'b0, dmem_if.dmem_req}, 32'd1);
            chk("req_stall", {31'b0, stall}, 32'd1);
            chk("req_addr", dmem_if.dmem_addr, exp_addr);
            chk("req_be", {28'b0, dmem_if.dmem_be}, {28'b0, exp_be});
            chk("req_wdata", dmem_if.dmem_wdata, exp_wdata);
            chk("req_we", {31'b0, dmem_if.dmem_we}, {31'b0, wr});
            next_cycle;
        end
        dmem_if.dmem_ack   = 1'b0;
        dmem_if.dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("done_stall", {31'b0, stall}, 32'd0);
        chk("done_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        next_cycle;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        chk("after_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        chk("after_stall", {31'b0, stall}, 32'd0);
        next_cycle;
    endtask

    initial begin
        rst_n              = 1'b1;
        MemRead            = 1'b0;
        MemWrite           = 1'b0;
        funct3             = 3'b000;
        addr               = 32'h0;
        wdata              = 32'h0;
        dmem_if.dmem_ack   = 1'b0;
        dmem_if.dmem_rdata = 32'h0;

        // Reset state
        @(negedge clk);
        chk("rst_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_if.dmem_we}, 32'd0);
        chk("rst_addr", dmem_if.dmem_addr, 32'h0);
        chk("rst_be", {28'b0, dmem_if.dmem_be}, 32'h0);
        chk("rst_wdata", dmem_if.dmem_wdata, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b0;

        // lw 0x100, immediate ack
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0,
               32'h100, 4'b1111, 32'h0);
        chk("lw_data", data, 32'hDEAD_BEEF);

        // ack while idle is ignored
        dmem_if.dmem_ack   = 1'b1;
        dmem_if.dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("idle_ack_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        chk("idle_ack_stall", {31'b0, stall}, 32'd0);
        next_cycle;
        dmem_if.dmem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_data", data, 32'hDEAD_BEEF);
        next_cycle;

        // lb / lbu 0x103
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0,
               32'h100, 4'b1000, 32'h0);
        chk("lb_data", data, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0,
               32'h100, 4'b1000, 32'h0);
        chk("lbu_data", data, 32'h0000_0080);

        // sh 0x102
        access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'hFFFF_FFFF, 0,
               32'h100, 4'b1100, 32'hABCD_ABCD);
        chk("sh_data_held", data, 32'h0000_0080);

        // lh 0x200, three wait cycles
        access(1'b1, 1'b0, 3'b001, 32'h200, 32'h0, 32'h1234_F00D, 3,
               32'h200, 4'b0011, 32'h0);
        chk("lh_data", data, 32'hFFFF_F00D);

        // lhu 0x202, one wait cycle
        access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h8001_7FFF, 1,
               32'h200, 4'b1100, 32'h0);
        chk("lhu_data", data, 32'h0000_8001);

        // sb 0x101 with read also asserted: write wins
        access(1'b1, 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'hFFFF_FFFF, 0,
               32'h100, 4'b0010, 32'hA5A5_A5A5);
        chk("sb_data_held", data, 32'h0000_8001);

        // lb 0x101 positive byte
        access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_7F00, 0,
               32'h100, 4'b0010, 32'h0);
        chk("lb_pos_data", data, 32'h0000_007F);

        // funct3 111 behaves as word store
        access(1'b0, 1'b1, 3'b111, 32'h204, 32'hCAFE_F00D, 32'h0, 0,
               32'h204, 4'b1111, 32'hCAFE_F00D);
        chk("sw111_data_held", data, 32'h0000_007F);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        // misaligned lw 0x101: no request, one stall cycle, one-cycle flag
        MemRead = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h101;
        @(negedge clk);
        chk("mis_idle_stall", {31'b0, stall}, 32'd1);
        chk("mis_idle_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        next_cycle;
        @(negedge clk);
        chk("mis_done_flag", {31'b0, misalign}, 32'd1);
        chk("mis_done_stall", {31'b0, stall}, 32'd0);
        chk("mis_done_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        chk("mis_done_data", data, 32'h0000_007F);
        next_cycle;
        MemRead = 1'b0;
        @(negedge clk);
        chk("mis_after_flag", {31'b0, misalign}, 32'd0);
        chk("mis_after_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        next_cycle;
`else
        // low address bits below the access size are ignored
        access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0BAD_C0DE, 0,
               32'h100, 4'b1111, 32'h0);
        chk("lw_unal_data", data, 32'h0BAD_C0DE);
        access(1'b1, 1'b0, 3'b001, 32'h203, 32'h0, 32'hABCD_1234, 0,
               32'h200, 4'b1100, 32'h0);
        chk("lh_unal_data", data, 32'hFFFF_ABCD);
`endif

        // reset in the middle of REQ
        MemRead = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h300;
        @(negedge clk);
        next_cycle;
        @(negedge clk);
        chk("mid_req_pre", {31'b0, dmem_if.dmem_req}, 32'd1);
        #2 rst_n = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        chk("mid_rst_addr", dmem_if.dmem_addr, 32'h0);
        chk("mid_rst_be", {28'b0, dmem_if.dmem_be}, 32'h0);
        chk("mid_rst_data", data, 32'h0);
        MemRead = 1'b0;
        #1 rst_n = 1'b0;
        next_cycle;
        dmem_if.dmem_ack   = 1'b1;
        dmem_if.dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("late_ack_req", {31'b0, dmem_if.dmem_req}, 32'd0);
        chk("late_ack_stall", {31'b0, stall}, 32'd0);
        next_cycle;
        dmem_if.dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_data", data, 32'h0);
        chk("late_ack_req2", {31'b0, dmem_if.dmem_req}, 32'd0);
        next_cycle;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
